quantize_zigzag: RTL and testbench

QUANTIZE_ZIGZAG -- requirements
Module: quantize_zigzag

---
 rtl/jpeg_pkg.sv | 54 +++++
 rtl/qz_mult.sv | 24 ++
 rtl/quantize_zigzag.sv | 102 ++++++++++
 tb/tb_quantize_zigzag.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG tables and types for the DCT and quantize/zigzag stages.
// QZ_ROUND_EN selects round-half-away-from-zero quantization; default truncates toward zero.
package jpeg_pkg;

    localparam int BLOCK_SIZE = 64;

    typedef enum logic {
        IDLE,
        EMIT
    } qz_state_e;

    // Raster index visited at each zigzag position.
    localparam logic [5:0] ZZ [BLOCK_SIZE] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    // Standard JPEG luminance quantizer, raster order.
    localparam logic [7:0] QL [BLOCK_SIZE] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    // min(255, round(256 / QL)), so division becomes a multiply and an 8-bit shift.
    localparam logic [7:0] RECIP [BLOCK_SIZE] = '{
        16, 23, 26, 16, 11,  6,  5,  4,
        21, 21, 18, 13, 10,  4,  4,  5,
        18, 20, 16, 11,  6,  4,  4,  5,
        18, 15, 12,  9,  5,  3,  3,  4,
        14, 12,  7,  5,  4,  2,  2,  3,
        11,  7,  5,  4,  3,  2,  2,  3,
         5,  4,  3,  3,  2,  2,  2,  3,
         4,  3,  3,  3,  2,  3,  2,  3
    };

`ifdef QZ_ROUND_EN
    localparam logic [15:0] QZ_ROUND = 16'd128;
`else
    localparam logic [15:0] QZ_ROUND = 16'd0;
`endif

endpackage

// File: rtl/qz_mult.sv
// Sign-magnitude quantizer: |c| * recip, optional half-LSB round, >> 8, saturate to 127, restore sign.
module qz_mult
    import jpeg_pkg::*;
(
    input  logic signed [7:0] coef,
    input  logic        [7:0] recip,
    output logic signed [7:0] q
);

    logic [7:0]  mag;
    logic [15:0] prod;
    logic [7:0]  shifted;
    logic [6:0]  sat;

    always_comb begin
        // -128 maps to magnitude 128, which still fits unsigned 8 bits.
        mag     = coef[7] ? (~coef + 8'd1) : coef;
        prod    = {8'd0, mag} * {8'd0, recip};
        shifted = 8'((prod + QZ_ROUND) >> 8);
        sat     = (shifted > 8'd127) ? 7'd127 : shifted[6:0];
        q       = coef[7] ? -$signed({1'b0, sat}) : $signed({1'b0, sat});
    end

endmodule

// File: rtl/quantize_zigzag.sv
// Captures an 8x8 DCT block, then streams its quantized coefficients in JPEG zigzag order.
// Rounding mode is selected by QZ_ROUND_EN (see jpeg_pkg).
module quantize_zigzag
    import jpeg_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] coef_in [BLOCK_SIZE],
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [7:0] out_data,
    output logic        [5:0] out_pos,
    output logic              out_last
);

    qz_state_e         state_q, state_d;
    logic        [5:0] pos_q, pos_d;
    logic signed [7:0] blk_q [BLOCK_SIZE];
    logic signed [7:0] blk_d [BLOCK_SIZE];
    logic signed [7:0] data_q, data_d;
    logic              last_q, last_d;

    logic        [5:0] next_pos;
    logic        [5:0] raster;
    logic signed [7:0] mult_coef;
    logic signed [7:0] mult_q;

    // The multiplier always works one position ahead so out_data can be registered:
    // in IDLE it quantizes the incoming DC term, in EMIT the next zigzag entry.
    assign next_pos  = pos_q + 6'd1;
    assign raster    = (state_q == IDLE) ? 6'd0 : ZZ[next_pos];
    assign mult_coef = (state_q == IDLE) ? coef_in[0] : blk_q[raster];

    qz_mult u_mult (
        .coef  (mult_coef),
        .recip (RECIP[raster]),
        .q     (mult_q)
    );

    always_comb begin
        // NOTE: every _d takes its _q value first so no path through this block infers a latch.
        state_d = state_q;
        pos_d   = pos_q;
        blk_d   = blk_q;
        data_d  = data_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = coef_in;
                    pos_d   = '0;
                    data_d  = mult_q;
                    last_d  = 1'b0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        pos_d   = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        pos_d  = next_pos;
                        data_d = mult_q;
                        last_d = (next_pos == 6'd63);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            // NOTE: the block buffer is reset too, so a discarded block can never leak out later.
            blk_q   <= '{default: '0};
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            blk_q   <= blk_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_data  = data_q;
    assign out_pos   = pos_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_quantize_zigzag.sv
// Self-checking bench for quantize_zigzag: arithmetic reference model plus directed block tests.
module tb_quantize_zigzag;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic              in_ready;
    logic              out_valid;
    logic              out_last;
    logic signed [7:0] coef [64];
    logic signed [7:0] out_data;
    logic        [5:0] out_pos;

    int vectors     = 0;
    int miscompares = 0;

`ifdef QZ_ROUND_EN
    localparam int R_M = 128;
`else
    localparam int R_M = 0;
`endif

    int ql_m [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };
    int zz_m [64];

    int exp_blk [64];
    int got_data [64];
    int got_count   = 0;
    int last_pos    = -1;
    int model_idx   = 0;
    int blocks      = 0;
    bit model_busy  = 1'b0;

    quantize_zigzag dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_in   (coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pos   (out_pos),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Walk the anti-diagonals, alternating direction, to build the zigzag order.
    task automatic build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int row = hi; row >= lo; row--) begin
                    zz_m[k] = row * 8 + (s - row);
                    k++;
                end
            end else begin
                for (int row = lo; row <= hi; row++) begin
                    zz_m[k] = row * 8 + (s - row);
                    k++;
                end
            end
        end
    endtask

    function automatic int recip_m(input int r);
        int v;
        v = (512 + ql_m[r]) / (2 * ql_m[r]);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int quant_m(input int c, input int r);
        int m;
        int q;
        m = (c < 0) ? -c : c;
        q = (m * recip_m(r) + R_M) / 256;
        if (q > 127) q = 127;
        return (c < 0) ? -q : q;
    endfunction

    // Reference model and per-cycle comparison, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_in_ready", int'(in_ready), 1);
                check("rst_out_data", int'($signed(out_data)), 0);
                check("rst_out_pos", int'(out_pos), 0);
                check("rst_out_last", int'(out_last), 0);
                model_busy = 1'b0;
                model_idx  = 0;
            end else begin
                check("in_ready", int'(in_ready), model_busy ? 0 : 1);
                check("out_valid", int'(out_valid), model_busy ? 1 : 0);
                if (model_busy) begin
                    check("out_data", int'($signed(out_data)), exp_blk[model_idx]);
                    check("out_pos", int'(out_pos), model_idx);
                    check("out_last", int'(out_last), (model_idx == 63) ? 1 : 0);
                end else begin
                    check("idle_out_data", int'($signed(out_data)), 0);
                    check("idle_out_pos", int'(out_pos), 0);
                    check("idle_out_last", int'(out_last), 0);
                end
                if (model_busy && out_ready) begin
                    check("accept_order", int'(out_pos), got_count);
                    if (got_count < 64) got_data[got_count] = int'($signed(out_data));
                    if (out_last) last_pos = int'(out_pos);
                    got_count++;
                    model_idx++;
                    if (model_idx == 64) model_busy = 1'b0;
                end else if (!model_busy && in_valid) begin
                    for (int p = 0; p < 64; p++)
                        exp_blk[p] = quant_m(int'(coef[zz_m[p]]), zz_m[p]);
                    model_busy = 1'b1;
                    model_idx  = 0;
                    got_count  = 0;
                    last_pos   = -1;
                    blocks++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_coef();
        for (int r = 0; r < 64; r++) coef[r] = '0;
    endtask

    task automatic ramp_coef();
        for (int r = 0; r < 64; r++) coef[r] = 8'(r * 37 + 13);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (model_busy && n < 300) begin
            step();
            n++;
        end
        check("wait_idle", int'(model_busy), 0);
    endtask

    task automatic wait_pos(input int target);
        int n = 0;
        while (int'(out_pos) != target && n < 200) begin
            step();
            n++;
        end
        check("wait_pos", int'(out_pos), target);
    endtask

    task automatic send_block();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_idle();
    endtask

    function automatic int count_nonzero_except(input int skip);
        int nz = 0;
        for (int p = 0; p < 64; p++)
            if (p != skip && got_data[p] != 0) nz++;
        return nz;
    endfunction

    initial begin
        int cyc;
        int nb;
        int n;

        build_zz();
        clear_coef();

        // Pin the reference model against hand-derived values.
        check("model_zz2", zz_m[2], 8);
        check("model_zz5", zz_m[5], 2);
        check("model_zz20", zz_m[20], 40);
        check("model_recip0", recip_m(0), 16);
        check("model_recip8", recip_m(8), 21);
        check("model_recip1", recip_m(1), 23);

        repeat (2) @(posedge clock);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        reset = 1'b0;
        step();

        // DC-only block.
        clear_coef();
        coef[0] = 8'sd64;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("dc_first_valid", int'(out_valid), 1);
        check("dc_first_pos", int'(out_pos), 0);
        check("dc_first_data", int'($signed(out_data)), 4);
        cyc = 1;
        while (!in_ready && cyc < 200) begin
            step();
            cyc++;
        end
        check("dc_in_ready_cycle", cyc, 65);
        check("dc_pos0", got_data[0], 4);
        check("dc_zero_rest", count_nonzero_except(0), 0);
        check("dc_count", got_count, 64);
        check("dc_last_pos", last_pos, 63);

        // Rounding: +40 at DC, -128 at raster 1.
        clear_coef();
        coef[0] = 8'sd40;
        coef[1] = -8'sd128;
        send_block();
`ifdef QZ_ROUND_EN
        check("round_40", got_data[0], 3);
        check("round_m128", got_data[1], -12);
`else
        check("round_40", got_data[0], 2);
        check("round_m128", got_data[1], -11);
`endif

        clear_coef();
        coef[0] = -8'sd100;
        send_block();
        check("round_m100", got_data[0], -6);

        // Zigzag order: raster 8 lands at position 2.
        clear_coef();
        coef[8] = 8'sd100;
        send_block();
        check("zz_pos2", got_data[2], 8);
        check("zz_zero_rest", count_nonzero_except(2), 0);

        // Backpressure at position 10.
        ramp_coef();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_pos(10);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_pos", int'(out_pos), 10);
            check("bp_hold_data", int'($signed(out_data)), quant_m(int'(coef[zz_m[10]]), zz_m[10]));
            check("bp_hold_last", int'(out_last), 0);
        end
        out_ready = 1'b1;
        step();
        check("bp_advance", int'(out_pos), 11);
        wait_idle();
        check("bp_count", got_count, 64);
        check("bp_data10", got_data[10], quant_m(int'(coef[zz_m[10]]), zz_m[10]));
        check("bp_data11", got_data[11], quant_m(int'(coef[zz_m[11]]), zz_m[11]));

        // Back-to-back: second block offered throughout the first.
        clear_coef();
        coef[8] = 8'sd100;
        nb = blocks;
        in_valid = 1'b1;
        step();
        clear_coef();
        coef[0] = 8'sd64;
        check("b2b_busy", int'(in_ready), 0);
        n = 0;
        while (blocks < nb + 2 && n < 300) begin
            step();
            n++;
        end
        in_valid = 1'b0;
        check("b2b_gap", n, 65);
        wait_idle();
        check("b2b_pos0", got_data[0], 4);
        check("b2b_pos2", got_data[2], 0);
        check("b2b_count", got_count, 64);

        // Reset in the middle of a block.
        ramp_coef();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_pos(30);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_pos", int'(out_pos), 0);
        check("mid_rst_data", int'($signed(out_data)), 0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_idle", int'(out_valid), 0);
        clear_coef();
        coef[0] = 8'sd64;
        send_block();
        check("post_rst_pos0", got_data[0], 4);
        check("post_rst_zero_rest", count_nonzero_except(0), 0);
        check("post_rst_count", got_count, 64);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
